// File: rtl/hack_cpu.sv
// Hack CPU core. Decodes A and C instructions and holds the A, D and PC
// registers. Includes the Hack ALU and resolves jumps from the ALU zr/ng flags.
module hack_cpu #(
   parameter logic [14:0] RESET_PC = 15'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [15:0] instruction,
   input  logic [15:0] in_m,
   output logic [15:0] out_m,
   output logic        write_m,
   output logic [14:0] address_m,
   output logic [14:0] pc
);

   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic [14:0] pc_reg;

   // decode fields
   logic        is_c;
   logic        sel_m;
   logic        zx, nx, zy, ny, fn, no;
   logic        dst_a, dst_d, dst_m;
   logic        jlt, jeq, jgt;

   assign is_c  = instruction[15];
   assign sel_m = instruction[12];
   assign zx    = instruction[11];
   assign nx    = instruction[10];
   assign zy    = instruction[9];
   assign ny    = instruction[8];
   assign fn    = instruction[7];
   assign no    = instruction[6];
   assign dst_a = instruction[5];
   assign dst_d = instruction[4];
   assign dst_m = instruction[3];
   assign jlt   = instruction[2];
   assign jeq   = instruction[1];
   assign jgt   = instruction[0];

   logic [15:0] x_in, y_in, x_pre, y_pre, alu_r, alu_out;
   logic        zr, ng, jump;
   logic [14:0] pc_inc;

   // ALU: x is D, y is A or M; the operands are the register values before this edge
   always_comb begin
      x_in    = d_reg;
      y_in    = sel_m ? in_m : a_reg;
      x_pre   = zx ? 16'h0000 : x_in;
      x_pre   = nx ? ~x_pre : x_pre;
      y_pre   = zy ? 16'h0000 : y_in;
      y_pre   = ny ? ~y_pre : y_pre;
      alu_r   = fn ? (x_pre + y_pre) : (x_pre & y_pre);
      alu_out = no ? ~alu_r : alu_r;
   end

   assign zr = (alu_out == 16'h0000);
   assign ng = alu_out[15];

   // jump resolution; 111 is unconditional because the three conditions cover every result
   always_comb begin
      jump = is_c & ((jlt & ng) | (jeq & zr) | (jgt & ~ng & ~zr));
   end

   assign pc_inc    = pc_reg + 15'd1;
   assign out_m     = alu_out;
   assign write_m   = is_c & dst_m & ~stall & ~reset;
   assign address_m = a_reg[14:0];
   assign pc        = pc_reg;

   // architectural state: reset beats stall, stall beats execute; jump target is pre-edge A
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg  <= 16'h0000;
         d_reg  <= 16'h0000;
         pc_reg <= RESET_PC;
      end else if (!stall) begin
         if (!is_c) begin
            a_reg  <= instruction;
            pc_reg <= pc_inc;
         end else begin
            if (dst_a) a_reg <= alu_out;
            if (dst_d) d_reg <= alu_out;
            pc_reg <= jump ? a_reg[14:0] : pc_inc;
         end
      end
   end

endmodule
